sram_ctrl: RTL and testbench
============================

Name: sram_ctrl

Overview:
- Synchronous bus-to-SRAM bridge for the rv32i core and an external 16-bit async SRAM (IS61WV25616 class).
- Converts one 32-bit request on a valid/ready bus into one or two timed 16-bit SRAM accesses.
- Supports byte strobes and a programmable number of wait cycles.
- The tristate pad is split into o/oe/i at top level; this block never drives `z`.

Parameters:
- SRAM_AW, 18, SRAM word (16-bit) address width; CPU word address is SRAM_AW-1 bits.
- WAIT, 1, extra strobe cycles per half access (0..15).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block idle, request accepted when valid&ready.
- req_we  in  1  1=write, 0=read.
- req_addr  in  SRAM_AW-1  32-bit word address.
- req_wdata  in  32  write data.
- req_wstrb  in  4  byte enables, bit i → byte i.
- rsp_done  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  read data, valid when rsp_done, held until next accept.
- sram_addr  out  SRAM_AW  SRAM address = {req_addr, half}.
- sram_ce_n  out  1  chip enable.
- sram_oe_n  out  1  output enable.
- sram_we_n  out  1  write enable.
- sram_lb_n  out  1  low byte enable.
- sram_ub_n  out  1  upper byte enable.
- sram_dq_o  out  16  write data to pad.
- sram_dq_oe  out  1  pad drive enable.
- sram_dq_i  in  16  pad read data.

Behaviour:
- All outputs are registered.
- Reset values:
  - req_ready=1, rsp_done=0, rsp_rdata=0.
  - sram_ce_n/oe_n/we_n/lb_n/ub_n=1.
  - sram_dq_oe=0, sram_addr=0, sram_dq_o=0.
- States: IDLE, ADDR, STROBE, HOLD. A half flag selects lo (0) or hi (1).
- IDLE:
  - ce_n=1, dq_oe=0, req_ready=1.
  - On valid&ready: latch we/addr/wdata/wstrb, ready→0, go ADDR.
- Half selection:
  - Reads always do lo then hi.
  - Writes do lo only if wstrb[1:0]≠0, and hi only if wstrb[3:2]≠0.
  - Write with wstrb=0: no SRAM activity; rsp_done pulses the cycle after accept.
- ADDR (1 cycle):
  - sram_addr valid, ce_n=0.
  - Read: lb_n=ub_n=0, oe_n=0.
  - Write: lb_n/ub_n from the relevant strobe pair (active-low), dq_o=relevant 16 bits, dq_oe=1, oe_n=1.
  - we_n=1.
- STROBE (WAIT+1 cycles, down-counter):
  - Write: we_n=0.
  - Read: on the clock edge leaving the final STROBE cycle, capture sram_dq_i into rsp_rdata[15:0] (lo) or [31:16] (hi).
- HOLD (1 cycle):
  - we_n=1, oe_n=1.
  - addr, dq_o and dq_oe unchanged (data hold for the write).
  - Then go ADDR for the hi half if needed; otherwise go IDLE, asserting rsp_done=1 and req_ready=1 in that first IDLE cycle.
- Latency, accept edge → rsp_done cycle:
  - Two halves: 2·(WAIT+3)+1.
  - One half: (WAIT+3)+1.
- Invariants:
  - we_n and oe_n never low in the same cycle.
  - dq_oe=0 whenever oe_n=0.
  - Address never changes while we_n=0.
- req_valid while busy is ignored (ready=0); there is no queueing.
- rsp_rdata bytes not read in a write transaction retain their old value.
- Reset mid-transaction, asynchronous:
  - Strobes deassert immediately and dq_oe=0.
  - The transaction is dropped with no rsp_done.
  - After release: IDLE, ready=1.
- Address arithmetic: no carry; the hi half is always word address | 1.

Decomposition:
- `sram_defs.vh` holds shared constants: state encodings, WAIT default, half selects lo=0/hi=1.
- No RTL sub-module is required; the wait counter is inline.
- Bench: a parametrised SRAM behavioural model with sram_dq split/merged at the bench top.

Test Plan:
1. Write 0xDEADBEEF to word 0x5 with wstrb=4'hF, WAIT=1.
   - SRAM words 0x0A=0xBEEF and 0x0B=0xDEAD.
   - rsp_done 9 cycles after accept.
2. Read word 0x5 after scenario 1.
   - rsp_rdata=0xDEADBEEF with rsp_done at cycle 9.
   - we_n stays 1 throughout.
3. Write 0x11223344 to word 0x5 with wstrb=4'b0100.
   - Only the hi half runs, with ub_n=1 and lb_n=0.
   - Word 0x0B becomes 0xDE22; word 0x0A stays unchanged.
   - rsp_done at cycle 5.
4. Write with wstrb=0.
   - rsp_done the cycle after accept.
   - ce_n stays 1 throughout.
5. Sweep WAIT=0 and WAIT=3 with a read.
   - rsp_done at cycles 7 and 13.
   - STROBE length 1 and 4 cycles respectively.
6. Assert rst_n low during the STROBE cycle of a write.
   - Same cycle: we_n=1, ce_n=1, dq_oe=0.
   - No rsp_done.
   - After release, a read returns the pre-write SRAM contents for the untouched half.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared constants and helpers for the bus-to-async-SRAM bridge.
// Holds the state encodings, the half selects and the latched request layout.
package sram_ctrl_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ADDR   = 2'd1;
    localparam logic [1:0] ST_STROBE = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    localparam logic HALF_LO = 1'b0;
    localparam logic HALF_HI = 1'b1;

    localparam int WAIT_DEFAULT = 1;

    typedef struct packed {
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } req_t;

    function automatic logic [1:0] strb_pair(input logic [3:0] wstrb, input logic half);
        return half ? wstrb[3:2] : wstrb[1:0];
    endfunction

    // Reads always touch both halves; writes skip a half with no enabled bytes.
    function automatic logic half_needed(input logic we, input logic [3:0] wstrb,
                                         input logic half);
        return !we || (strb_pair(wstrb, half) != 2'b00);
    endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// Valid/ready request and completion bus between the core and the SRAM bridge.
interface sram_ctrl_if #(
    parameter int SRAM_AW = 18
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [SRAM_AW-2:0]   req_addr;
    logic [31:0]          req_wdata;
    logic [3:0]           req_wstrb;
    logic                 rsp_done;
    logic [31:0]          rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb,
        input  req_ready, rsp_done, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
        output req_ready, rsp_done, rsp_rdata
    );
endinterface

// File: rtl/sram_ctrl.sv
// Bridge from a 32-bit valid/ready bus to a 16-bit async SRAM, one or two
// timed half accesses per request, all pad controls driven from flops.
//
// state  | meaning
// IDLE   | ready for a request, SRAM deselected
// ADDR   | address/byte enables set up, ce_n low, strobes inactive
// STROBE | we_n low for writes, read data settling; WAIT+1 cycles
// HOLD   | strobes released, address/data held one cycle
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int SRAM_AW = 18,
    parameter int WAIT    = WAIT_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    sram_ctrl_if.slave         bus,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic               sram_lb_n,
    output logic               sram_ub_n,
    output logic [15:0]        sram_dq_o,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_i
);

    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    logic [1:0]         state_q, state_d;
    logic               half_q, half_d;
    logic [3:0]         cnt_q, cnt_d;
    req_t               req_q, req_d;
    logic [SRAM_AW-2:0] addr_q, addr_d;

    logic               ready_q, ready_d;
    logic               done_q, done_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
    logic               ce_n_q, ce_n_d;
    logic               oe_n_q, oe_n_d;
    logic               we_n_q, we_n_d;
    logic               lb_n_q, lb_n_d;
    logic               ub_n_q, ub_n_d;
    logic [15:0]        dq_o_q, dq_o_d;
    logic               dq_oe_q, dq_oe_d;

    logic               accept;
    logic               launch;
    logic               launch_half;
    logic [1:0]         pair;

    assign accept = bus.req_valid && ready_q;

    always_comb begin
        state_d     = state_q;
        half_d      = half_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        addr_d      = addr_q;
        ready_d     = ready_q;
        done_d      = 1'b0;
        rdata_d     = rdata_q;
        sram_addr_d = sram_addr_q;
        ce_n_d      = ce_n_q;
        oe_n_d      = oe_n_q;
        we_n_d      = we_n_q;
        lb_n_d      = lb_n_q;
        ub_n_d      = ub_n_q;
        dq_o_d      = dq_o_q;
        dq_oe_d     = dq_oe_q;
        launch      = 1'b0;
        launch_half = HALF_LO;
        pair        = 2'b00;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    req_d.we    = bus.req_we;
                    req_d.wstrb = bus.req_wstrb;
                    req_d.wdata = bus.req_wdata;
                    addr_d      = bus.req_addr;
                    if (bus.req_we && bus.req_wstrb == 4'b0000) begin
                        done_d = 1'b1;
                    end else begin
                        launch      = 1'b1;
                        launch_half = half_needed(bus.req_we, bus.req_wstrb, HALF_LO)
                                      ? HALF_LO : HALF_HI;
                    end
                end
            end
            ST_ADDR: begin
                state_d = ST_STROBE;
                cnt_d   = WAIT_CNT;
                we_n_d  = !req_q.we;
            end
            ST_STROBE: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_HOLD;
                    we_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    if (!req_q.we) begin
                        if (half_q == HALF_HI) rdata_d[31:16] = sram_dq_i;
                        else                   rdata_d[15:0]  = sram_dq_i;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                if (half_q == HALF_LO && half_needed(req_q.we, req_q.wstrb, HALF_HI)) begin
                    launch      = 1'b1;
                    launch_half = HALF_HI;
                end else begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                    done_d  = 1'b1;
                    ce_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    we_n_d  = 1'b1;
                    lb_n_d  = 1'b1;
                    ub_n_d  = 1'b1;
                    dq_oe_d = 1'b0;
                end
            end
        endcase

        // Common ADDR-phase setup, shared by the first half and the hi half.
        if (launch) begin
            state_d     = ST_ADDR;
            half_d      = launch_half;
            ready_d     = 1'b0;
            sram_addr_d = {addr_d, launch_half};
            ce_n_d      = 1'b0;
            we_n_d      = 1'b1;
            if (req_d.we) begin
                pair    = strb_pair(req_d.wstrb, launch_half);
                lb_n_d  = !pair[0];
                ub_n_d  = !pair[1];
                oe_n_d  = 1'b1;
                dq_oe_d = 1'b1;
                dq_o_d  = launch_half ? req_d.wdata[31:16] : req_d.wdata[15:0];
            end else begin
                lb_n_d  = 1'b0;
                ub_n_d  = 1'b0;
                oe_n_d  = 1'b0;
                dq_oe_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            half_q      <= HALF_LO;
            cnt_q       <= 4'd0;
            req_q       <= '0;
            addr_q      <= '0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            rdata_q     <= '0;
            sram_addr_q <= '0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            lb_n_q      <= 1'b1;
            ub_n_q      <= 1'b1;
            dq_o_q      <= '0;
            dq_oe_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            half_q      <= half_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            rdata_q     <= rdata_d;
            sram_addr_q <= sram_addr_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            lb_n_q      <= lb_n_d;
            ub_n_q      <= ub_n_d;
            dq_o_q      <= dq_o_d;
            dq_oe_q     <= dq_oe_d;
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_done  = done_q;
    assign bus.rsp_rdata = rdata_q;
    assign sram_addr     = sram_addr_q;
    assign sram_ce_n     = ce_n_q;
    assign sram_oe_n     = oe_n_q;
    assign sram_we_n     = we_n_q;
    assign sram_lb_n     = lb_n_q;
    assign sram_ub_n     = ub_n_q;
    assign sram_dq_o     = dq_o_q;
    assign sram_dq_oe    = dq_oe_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: three instances (WAIT=0,1,3); the WAIT=1 one
// talks to a byte-laned SRAM model, the others see an address-derived pattern.
module tb_sram_ctrl;

    logic        clk;
    logic        rst_n;
    logic [2:0]  vld;
    logic        req_we;
    logic [16:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;

    logic        ready_w [3];
    logic        done_w  [3];
    logic [31:0] rdata_w [3];
    logic [17:0] saddr   [3];
    logic        ce_n    [3];
    logic        oe_n    [3];
    logic        we_n    [3];
    logic        lb_n    [3];
    logic        ub_n    [3];
    logic [15:0] dq_o    [3];
    logic        dq_oe   [3];
    logic [15:0] dq_i    [3];

    logic [15:0] mem [1024];
    logic        mdl_we_prev;

    int total = 0;
    int bad   = 0;
    int inv_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        sram_ctrl_if #(.SRAM_AW(18)) bus ();
        assign bus.req_valid = vld[g];
        assign bus.req_we    = req_we;
        assign bus.req_addr  = req_addr;
        assign bus.req_wdata = req_wdata;
        assign bus.req_wstrb = req_wstrb;
        assign ready_w[g]    = bus.req_ready;
        assign done_w[g]     = bus.rsp_done;
        assign rdata_w[g]    = bus.rsp_rdata;

        sram_ctrl #(.SRAM_AW(18), .WAIT((g == 2) ? 3 : g)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .bus        (bus),
            .sram_addr  (saddr[g]),
            .sram_ce_n  (ce_n[g]),
            .sram_oe_n  (oe_n[g]),
            .sram_we_n  (we_n[g]),
            .sram_lb_n  (lb_n[g]),
            .sram_ub_n  (ub_n[g]),
            .sram_dq_o  (dq_o[g]),
            .sram_dq_oe (dq_oe[g]),
            .sram_dq_i  (dq_i[g])
        );
    end

    assign dq_i[0] = saddr[0][15:0] ^ 16'h5A00;
    assign dq_i[2] = saddr[2][15:0] ^ 16'h5A00;
    assign dq_i[1] = (!ce_n[1] && !oe_n[1]) ? mem[saddr[1][9:0]] : 16'hFFFF;

    // Write commits on the rising edge of we_n while the chip is still selected.
    always @(negedge clk) begin
        if (mdl_we_prev && we_n[1] && !ce_n[1]) begin
            if (!lb_n[1]) mem[saddr[1][9:0]][7:0]  = dq_o[1][7:0];
            if (!ub_n[1]) mem[saddr[1][9:0]][15:8] = dq_o[1][15:8];
        end
        mdl_we_prev = !we_n[1];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic txn(input int k, input logic we, input logic [16:0] a,
                       input logic [31:0] wd, input logic [3:0] ws,
                       output int lat, output logic [31:0] rd, output int ce_cnt,
                       output int we_cnt, output int we_runs, output int oe_max,
                       output logic [1:0] ublb);
        logic        we_prev;
        int          orun;
        logic [17:0] a_prev;
        lat = -1; rd = '0; ce_cnt = 0; we_cnt = 0; we_runs = 0; oe_max = 0;
        ublb = 2'b11; we_prev = 1'b0; orun = 0; a_prev = '0;
        @(negedge clk);
        req_we = we; req_addr = a; req_wdata = wd; req_wstrb = ws;
        vld[k] = 1'b1;
        chk("ready_before_accept", 32'(ready_w[k]), 32'd1);
        @(posedge clk);
        #1 vld[k] = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (!ce_n[k]) ce_cnt++;
            if (!we_n[k]) begin
                we_cnt++;
                ublb = {ub_n[k], lb_n[k]};
                if (!we_prev) we_runs++;
                else if (saddr[k] != a_prev) inv_bad++;
            end
            we_prev = !we_n[k];
            a_prev  = saddr[k];
            if (!oe_n[k]) begin
                orun++;
                if (orun > oe_max) oe_max = orun;
            end else begin
                orun = 0;
            end
            if ((!we_n[k] && !oe_n[k]) || (!oe_n[k] && dq_oe[k])) inv_bad++;
            if (done_w[k]) begin
                lat = c;
                rd  = rdata_w[k];
                break;
            end
        end
    endtask

    initial begin
        int          lat, ce_cnt, we_cnt, we_runs, oe_max, done_seen;
        logic [31:0] rd;
        logic [1:0]  ublb;

        mdl_we_prev = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        rst_n = 1'b0; vld = '0;
        req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("rst_ready", 32'(ready_w[1]), 32'd1);
        chk("rst_done", 32'(done_w[1]), 32'd0);
        chk("rst_rdata", rdata_w[1], 32'h0);
        chk("rst_strobes", 32'({ce_n[1], oe_n[1], we_n[1], lb_n[1], ub_n[1]}), 32'h1F);
        chk("rst_dq_oe", 32'(dq_oe[1]), 32'd0);
        chk("rst_addr_dq", {14'(saddr[1]), dq_o[1]}, 32'h0);

        // Full-word write
        txn(1, 1'b1, 17'h5, 32'hDEADBEEF, 4'hF, lat, rd, ce_cnt, we_cnt, we_runs, oe_max, ublb);
        chk("wr_full_lat", 32'(lat), 32'd9);
        chk("wr_full_lo", 32'(mem[10'h0A]), 32'h0000BEEF);
        chk("wr_full_hi", 32'(mem[10'h0B]), 32'h0000DEAD);
        chk("wr_full_runs", 32'(we_runs), 32'd2);
        chk("wr_full_oe", 32'(oe_max), 32'd0);

        // Read back
        txn(1, 1'b0, 17'h5, 32'h0, 4'h0, lat, rd, ce_cnt, we_cnt, we_runs, oe_max, ublb);
        chk("rd_lat", 32'(lat), 32'd9);
        chk("rd_data", rd, 32'hDEADBEEF);
        chk("rd_no_we", 32'(we_cnt), 32'd0);

        // Single-byte write into the hi half
        txn(1, 1'b1, 17'h5, 32'h11223344, 4'b0100, lat, rd, ce_cnt, we_cnt, we_runs, oe_max, ublb);
        chk("wr_b2_lat", 32'(lat), 32'd5);
        chk("wr_b2_ublb", 32'(ublb), 32'b10);
        chk("wr_b2_runs", 32'(we_runs), 32'd1);
        chk("wr_b2_lo", 32'(mem[10'h0A]), 32'h0000BEEF);
        chk("wr_b2_hi", 32'(mem[10'h0B]), 32'h0000DE22);
        chk("rdata_hold", rdata_w[1], 32'hDEADBEEF);

        // Empty write
        txn(1, 1'b1, 17'h7, 32'hCAFEF00D, 4'h0, lat, rd, ce_cnt, we_cnt, we_runs, oe_max, ublb);
        chk("wr_none_lat", 32'(lat), 32'd1);
        chk("wr_none_ce", 32'(ce_cnt), 32'd0);

        // WAIT sweep
        txn(0, 1'b0, 17'h21, 32'h0, 4'h0, lat, rd, ce_cnt, we_cnt, we_runs, oe_max, ublb);
        chk("w0_lat", 32'(lat), 32'd7);
        chk("w0_data", rd, 32'h5A435A42);
        chk("w0_oe_len", 32'(oe_max), 32'd2);
        txn(2, 1'b0, 17'h3F, 32'h0, 4'h0, lat, rd, ce_cnt, we_cnt, we_runs, oe_max, ublb);
        chk("w3_lat", 32'(lat), 32'd13);
        chk("w3_data", rd, 32'h5A7F5A7E);
        chk("w3_oe_len", 32'(oe_max), 32'd5);

        // Reset during the first STROBE cycle of a write
        @(negedge clk);
        req_we = 1'b1; req_addr = 17'h5; req_wdata = 32'h12345678; req_wstrb = 4'hF;
        vld[1] = 1'b1;
        @(posedge clk);
        #1 vld[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_we_pre", 32'(we_n[1]), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_pins", 32'({we_n[1], ce_n[1], dq_oe[1]}), 32'b110);
        done_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done_w[1]) done_seen++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done_w[1]) done_seen++;
        end
        chk("rst_mid_no_done", 32'(done_seen), 32'd0);
        chk("rst_mid_ready", 32'(ready_w[1]), 32'd1);
        txn(1, 1'b0, 17'h5, 32'h0, 4'h0, lat, rd, ce_cnt, we_cnt, we_runs, oe_max, ublb);
        chk("rst_mid_readback", rd, 32'hDE22BEEF);

        chk("invariants", 32'(inv_bad), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
